// File: rtl/card_dealer.sv
// card_dealer: deals two LFSR-driven cards per round, shows a decaying score,
// ends rounds on bell or timeout. Optional macro CARD_LOAD_EN adds card loading.
module card_dealer #(
  parameter logic [7:0]  CNT_INIT   = 8'd100,
  parameter int          TICK_DIV   = 16,
  parameter int          GAP_CYCLES = 8,
  parameter int          NUM_ROUNDS = 16,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bell,
  output logic [1:0] c1,
  output logic [1:0] c2,
  output logic [2:0] n1,
  output logic [2:0] n2,
  output logic [7:0] count,
  output logic       card_valid,
  output logic       round_done,
  output logic       timeout,
  output logic       game_over
`ifdef CARD_LOAD_EN
  ,
  input  logic       load_en,
  input  logic [9:0] load_cards
`endif
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [7:0]    ROUNDS    = 8'(NUM_ROUNDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DEAL = 3'd1;
  localparam logic [2:0] S_SHOW = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [15:0]   lfsr_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    round_q, round_d;
  logic [7:0]    count_q, count_d;
  logic [1:0]    c1_q, c1_d, c2_q, c2_d;
  logic [2:0]    n1_q, n1_d, n2_q, n2_d;
  logic          rd_q, rd_d;
  logic          to_q, to_d;
  logic          go_q, go_d;
  logic [9:0]    src;

  // Card numbers fold 0..7 onto 1..5.
  function automatic logic [2:0] map5(input logic [2:0] r);
    return (r >= 3'd5) ? r - 3'd4 : r + 3'd1;
  endfunction

`ifdef CARD_LOAD_EN
  assign src = load_en ? load_cards : lfsr_q[9:0];
`else
  assign src = lfsr_q[9:0];
`endif

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Round sequencing, score decay and card latching.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    gap_d   = gap_q;
    round_d = round_q;
    count_d = count_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    to_d    = to_q;
    go_d    = go_q;
    rd_d    = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_DEAL;
      S_DEAL: begin
        n1_d    = map5(src[2:0]);
        c1_d    = src[4:3];
        n2_d    = map5(src[7:5]);
        c2_d    = src[9:8];
        count_d = CNT_INIT;
        tick_d  = '0;
        to_d    = 1'b0;
        round_d = round_q + 8'd1;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (bell) begin
          rd_d    = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (count_q == 8'd0) begin
            to_d    = 1'b1;
            rd_d    = 1'b1;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            count_d = count_q - 8'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (round_q == ROUNDS) begin
            go_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DEAL;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: begin
        if (start) begin
          go_d    = 1'b0;
          round_d = '0;
          state_d = S_DEAL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any round silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      gap_q   <= '0;
      round_q <= '0;
      count_q <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      rd_q    <= 1'b0;
      to_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      round_q <= round_d;
      count_q <= count_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      rd_q    <= rd_d;
      to_q    <= to_d;
      go_q    <= go_d;
    end
  end

  assign c1         = c1_q;
  assign c2         = c2_q;
  assign n1         = n1_q;
  assign n2         = n2_q;
  assign count      = count_q;
  assign card_valid = (state_q == S_SHOW);
  assign round_done = rd_q;
  assign timeout    = to_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: scoreboard bench for card_dealer.
// Deals, bell, timeout, game end, restart and mid-round reset.
module tb_card_dealer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst, start, bell;
  logic [1:0] c1, c2;
  logic [2:0] n1, n2;
  logic [7:0] count;
  logic       card_valid, round_done, timeout, game_over;
`ifdef CARD_LOAD_EN
  logic       load_en = 1'b0;
  logic [9:0] load_cards = '0;
`endif

  always #5 clk = ~clk;

  card_dealer #(
    .CNT_INIT(8'd100), .TICK_DIV(4), .GAP_CYCLES(8),
    .NUM_ROUNDS(2), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bell(bell),
    .c1(c1), .c2(c2), .n1(n1), .n2(n2), .count(count),
    .card_valid(card_valid), .round_done(round_done),
    .timeout(timeout), .game_over(game_over)
`ifdef CARD_LOAD_EN
    , .load_en(load_en), .load_cards(load_cards)
`endif
  );

  typedef struct packed {
    logic [1:0] c1;
    logic [2:0] n1;
    logic [1:0] c2;
    logic [2:0] n2;
  } cards_t;

  int total = 0;
  int bad = 0;
  cards_t     cq[$];
  logic [8:0] rq[$];
  logic [2:0] tbl [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3};
  logic [15:0] mlfsr;
  logic pcv = 1'b0;

  // Reference LFSR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mlfsr <= SEED;
    else mlfsr <= {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tk;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_cards(input logic [9:0] s);
    cards_t e;
    e.n1 = tbl[s[2:0]];
    e.c1 = s[4:3];
    e.n2 = tbl[s[7:5]];
    e.c2 = s[9:8];
    cq.push_back(e);
  endtask

  task automatic push_rd(input logic to, input logic [7:0] cnt);
    rq.push_back({to, cnt});
  endtask

  // Monitor: compares each deal and each round end against the queues.
  always @(negedge clk) begin
    cards_t e;
    logic [8:0] r;
    if (rst) begin
      pcv = 1'b0;
    end else begin
      if (card_valid && !pcv) begin
        if (cq.size() == 0) begin
          chk("unexpected_deal", 1, 0);
        end else begin
          e = cq.pop_front();
          chk("n1", 32'(n1), 32'(e.n1));
          chk("c1", 32'(c1), 32'(e.c1));
          chk("n2", 32'(n2), 32'(e.n2));
          chk("c2", 32'(c2), 32'(e.c2));
        end
      end
      if (round_done) begin
        if (rq.size() == 0) begin
          chk("unexpected_round_done", 1, 0);
        end else begin
          r = rq.pop_front();
          chk("rd_timeout", 32'(timeout), 32'(r[8]));
          chk("rd_count", 32'(count), 32'(r[7:0]));
        end
      end
      pcv = card_valid;
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_cards"}, 32'({c1, c2, n1, n2}), 0);
    chk({nm, "_count"}, 32'(count), 0);
    chk({nm, "_flags"}, 32'({card_valid, round_done, timeout, game_over}), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    bell = 1'b0;
    repeat (3) tk();
    check_zero("reset");
    rst = 1'b0;
    start = 1'b0;
    repeat (4) tk();
    chk("idle_after_reset", 32'(card_valid), 0);

    // Game 1, round 1: start latency and decay, bell on a tick edge
    start = 1'b1;
    tk();
    start = 1'b0;
    push_cards(mlfsr[9:0]);
    chk("deal_not_shown", 32'(card_valid), 0);
    tk();
    chk("show_latency", 32'(card_valid), 1);
    chk("count_init", 32'(count), 100);
    repeat (8) tk();
    chk("count_after_8", 32'(count), 98);
    repeat (7) tk();
    chk("count_cycle16", 32'(count), 97);
    push_rd(1'b0, 8'd97);
    bell = 1'b1;
    tk();
    chk("rd_pulse_bell", 32'(round_done), 1);
    chk("gap_hidden", 32'(card_valid), 0);
    tk();
    chk("rd_one_cycle", 32'(round_done), 0);
    tk();
    bell = 1'b0;
    chk("gap_count_hold", 32'(count), 97);
    repeat (5) tk();
    chk("gap_end_count", 32'(count), 97);
    chk("gap_end_hidden", 32'(card_valid), 0);

    // Round 2: run to timeout
    tk();
    push_cards(mlfsr[9:0]);
    tk();
    chk("r2_show", 32'(card_valid), 1);
    chk("r2_count", 32'(count), 100);
    push_rd(1'b1, 8'd0);
    repeat (403) tk();
    chk("count_floor", 32'(count), 0);
    chk("no_rd_yet", 32'(round_done), 0);
    tk();
    chk("rd_pulse_timeout", 32'(round_done), 1);
    repeat (7) tk();
    chk("not_over_yet", 32'(game_over), 0);
    tk();
    chk("game_over", 32'(game_over), 1);
    bell = 1'b1;
    repeat (2) tk();
    bell = 1'b0;
    chk("done_hold_over", 32'(game_over), 1);
    chk("done_hold_count", 32'(count), 0);
    chk("done_timeout_held", 32'(timeout), 1);

    // Game 2: restart clears the round counter
    start = 1'b1;
    tk();
    start = 1'b0;
    chk("restart_clear", 32'(game_over), 0);
    push_cards(mlfsr[9:0]);
    tk();
    chk("g2_show", 32'(card_valid), 1);
    push_rd(1'b0, 8'd100);
    bell = 1'b1;
    tk();
    bell = 1'b0;
    repeat (8) tk();
    push_cards(mlfsr[9:0]);
    tk();
    chk("g2_r2_show", 32'(card_valid), 1);
    chk("g2_r2_not_over", 32'(game_over), 0);

    // Reset mid-round
    repeat (2) tk();
    #2 rst = 1'b1;
    #1 check_zero("mid_reset");
    tk();
    rst = 1'b0;
    bell = 1'b1;
    repeat (3) tk();
    bell = 1'b0;
    chk("post_reset_idle", 32'(card_valid), 0);

    // Deal after reset
`ifdef CARD_LOAD_EN
    load_en = 1'b1;
    load_cards = 10'b10_100_01_111;
`endif
    start = 1'b1;
    tk();
    start = 1'b0;
`ifdef CARD_LOAD_EN
    push_cards(10'b10_100_01_111);
`else
    push_cards(mlfsr[9:0]);
`endif
    tk();
`ifdef CARD_LOAD_EN
    load_en = 1'b0;
`endif
    chk("last_show", 32'(card_valid), 1);
    tk();
    chk("cards_consumed", 32'(cq.size()), 0);
    chk("rounds_consumed", 32'(rq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
